// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: operation codes, FSM states, iteration count.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FINISH = 2'b10
  } muldiv_state_t;

  localparam int ITER_COUNT = 32;

  function automatic logic is_signed_op(input muldiv_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Unsigned iterative engine: one shift-add or restoring shift-subtract step per i_step.
// No flow control; the wrapping FSM decides when to load and step. Result sits in o_acc.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = ITER_COUNT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_load,
  input  logic                    i_step,
  input  logic                    i_div,
  input  logic [DATA_WIDTH-1:0]   i_a,
  input  logic [DATA_WIDTH-1:0]   i_b,
  output logic [2*DATA_WIDTH-1:0] o_acc
);
  localparam int W = DATA_WIDTH;

  logic [W-1:0]   r_opnd;
  logic           r_div;
  logic [2*W-1:0] r_acc;
  logic [W:0]     w_sum;
  logic [W:0]     w_trial;
  logic [2*W-1:0] w_next;

  // Multiply: acc = {partial, multiplier}, shift right. Divide: acc = {remainder, dividend},
  // shift left and try subtracting the divisor from the 33-bit upper window.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_trial = r_acc[2*W-1:W-1] - {1'b0, r_opnd};
    if (r_div) begin
      if (!w_trial[W]) w_next = {w_trial[W-1:0], r_acc[W-2:0], 1'b1};
      else             w_next = {r_acc[2*W-2:0], 1'b0};
    end else begin
      w_next = {w_sum, r_acc[W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_opnd <= '0;
      r_div  <= 1'b0;
      r_acc  <= '0;
    end else if (i_load) begin
      r_opnd <= i_div ? i_b : i_a;
      r_div  <= i_div;
      r_acc  <= {{W{1'b0}}, (i_div ? i_a : i_b)};
    end else if (i_step) begin
      r_acc  <= w_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/muldiv_hilo.sv
// MULT/MULTU/DIV/DIVU unit with HI/LO; 33 busy cycles per op, results visible after the done cycle.
// start/mthi/mtlo are dropped while busy (no queuing); the core stalls on busy.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = ITER_COUNT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  muldiv_state_t  r_state, w_next_state;
  logic [CW-1:0]  r_count;
  logic           w_load, w_step, w_finish;
  logic           r_neg_q, r_neg_r, r_is_div, r_div0;
  logic [W-1:0]   r_hi, r_lo;

  muldiv_op_t     w_op;
  logic           w_a_neg, w_b_neg;
  logic [W-1:0]   w_a_mag, w_b_mag;
  logic [2*W-1:0] w_acc, w_prod;
  logic [W-1:0]   w_quot, w_rem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_count == LAST) w_next_state = FINISH;
      end
      FINISH: begin
        w_finish     = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_count <= '0;
    else if (w_load) r_count <= '0;
    else if (w_step) r_count <= r_count + 1'b1;
  end

  // The engine only sees magnitudes; signs are reapplied when HI/LO are written.
  assign w_op    = muldiv_op_t'(op);
  assign w_a_neg = is_signed_op(w_op) & a[W-1];
  assign w_b_neg = is_signed_op(w_op) & b[W-1];
  assign w_a_mag = w_a_neg ? -a : a;
  assign w_b_mag = w_b_neg ? -b : b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_div0   <= 1'b0;
    end else if (w_load) begin
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_is_div <= op[1];
      r_div0   <= op[1] && (b == '0);
    end
  end

  muldiv_core #(.DATA_WIDTH(W)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_div   (op[1]),
    .i_a     (w_a_mag),
    .i_b     (w_b_mag),
    .o_acc   (w_acc)
  );

  assign w_prod = r_neg_q ? -w_acc : w_acc;
  assign w_quot = r_neg_q ? -w_acc[W-1:0] : w_acc[W-1:0];
  assign w_rem  = r_neg_r ? -w_acc[2*W-1:W] : w_acc[2*W-1:W];

  // Start takes priority over MT writes in IDLE; divide-by-zero leaves HI/LO untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_finish) begin
      if (!r_div0) begin
        r_hi <= r_is_div ? w_rem  : w_prod[2*W-1:W];
        r_lo <= r_is_div ? w_quot : w_prod[W-1:0];
      end
    end else if (r_state == IDLE && !start) begin
      if (mthi) r_hi <= wdata;
      if (mtlo) r_lo <= wdata;
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == FINISH);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: expected HI:LO pushed at launch, popped when done retires.
module tb_muldiv_hilo;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] exp_q[$];

  muldiv_hilo #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, q, r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (o)
      2'd0: return sx * sy;
      2'd1: return {32'd0, x} * {32'd0, y};
      2'd2: begin q = sx / sy; r = sx % sy; return {r[31:0], q[31:0]}; end
      default: return {x % y, x / y};
    endcase
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(output int nbusy, output bit seen);
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", hi); else n_pass++;
    n_checks++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", lo); else n_pass++;
  endtask

  task automatic test_arith;
    logic [1:0]  t_op  [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd2};
    logic [31:0] t_a   [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100,
                               32'h80000000, 32'h80000000, 32'd7};
    logic [31:0] t_b   [7] = '{32'd5, 32'hFFFFFFFF, 32'd2, 32'd7, 32'hFFFFFFFF,
                               32'h80000000, 32'hFFFFFFFE};
    logic [63:0] t_exp [7] = '{64'hFFFFFFFF_FFFFFFF1, 64'hFFFFFFFE_00000001,
                               64'hFFFFFFFF_FFFFFFFD, 64'h00000002_0000000E,
                               64'h00000000_80000000, 64'h40000000_00000000,
                               64'h00000001_FFFFFFFD};
    int nb; bit seen; logic [63:0] e;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(t_exp[i]);
      launch(t_op[i], t_a[i], t_b[i]);
      wait_done(nb, seen);
      n_checks++; if (!seen) $display("FAIL arith%0d_done: got 0 want 1", i); else n_pass++;
      n_checks++; if (nb !== 33) $display("FAIL arith%0d_busy_cycles: got %0d want 33", i, nb); else n_pass++;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++; if (busy !== 1'b0 || done !== 1'b0)
        $display("FAIL arith%0d_idle: got busy=%b done=%b want 0 0", i, busy, done); else n_pass++;
      n_checks++; if (hi !== e[63:32]) $display("FAIL arith%0d_hi: got %h want %h", i, hi, e[63:32]); else n_pass++;
      n_checks++; if (lo !== e[31:0])  $display("FAIL arith%0d_lo: got %h want %h", i, lo, e[31:0]); else n_pass++;
    end
  endtask

  task automatic test_random;
    int nb; bit seen; logic [63:0] e; logic [1:0] o; logic [31:0] x, y;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      x = (i < 4) ? 32'($urandom_range(0, 300)) - 32'd150 : $urandom;
      y = (i < 4) ? 32'($urandom_range(0, 30)) - 32'd15 : $urandom;
      if (o[1] && y == 32'd0) y = 32'd3;
      exp_q.push_back(model(o, x, y));
      launch(o, x, y);
      wait_done(nb, seen);
      n_checks++; if (!seen) $display("FAIL rand%0d_done: got 0 want 1", i); else n_pass++;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++; if ({hi, lo} !== e)
        $display("FAIL rand%0d_hilo op=%0d a=%h b=%h: got %h want %h", i, o, x, y, {hi, lo}, e); else n_pass++;
    end
  endtask

  task automatic test_mt_div0;
    int nb; bit seen; logic [63:0] e;
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFEF00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    n_checks++; if ({hi, lo} !== 64'hCAFEF00D_CAFEF00D)
      $display("FAIL mt_both: got %h want cafef00dcafef00d", {hi, lo}); else n_pass++;
    mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    mtlo = 1'b0;
    n_checks++; if ({hi, lo} !== 64'h00001234_00005678)
      $display("FAIL mt_separate: got %h want 0000123400005678", {hi, lo}); else n_pass++;
    exp_q.push_back(64'h00001234_00005678);
    launch(2'd3, 32'd55, 32'd0);
    wait_done(nb, seen);
    n_checks++; if (!seen || nb !== 33)
      $display("FAIL div0_timing: got seen=%b busy=%0d want 1 33", seen, nb); else n_pass++;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++; if ({hi, lo} !== e) $display("FAIL div0_hilo: got %h want %h", {hi, lo}, e); else n_pass++;
    // start with MT writes in the same IDLE cycle: the writes must be dropped
    exp_q.push_back(64'h00000000_00000006);
    start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd3; mthi = 1'b1; mtlo = 1'b1; wdata = 32'hFFFF;
    @(posedge clk);
    #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || {hi, lo} !== 64'h00001234_00005678)
      $display("FAIL start_wins: got busy=%b hilo=%h want 1 0000123400005678", busy, {hi, lo}); else n_pass++;
    wait_done(nb, seen);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++; if ({hi, lo} !== e) $display("FAIL start_wins_result: got %h want %h", {hi, lo}, e); else n_pass++;
  endtask

  task automatic test_abort_busy;
    int nb, ndone; bit seen; logic [63:0] e;
    launch(2'd0, 32'd7, 32'd9);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if ({hi, lo} !== 64'h0) $display("FAIL abort_hilo: got %h want 0", {hi, lo}); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (i == 3) reset_n = 1'b1;
    end
    n_checks++; if (ndone !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", ndone); else n_pass++;
    exp_q.push_back(64'd63);
    launch(2'd0, 32'd7, 32'd9);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd100; b = 32'd100; mthi = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    wait_done(nb, seen);
    n_checks++; if (!seen || nb !== 27)
      $display("FAIL busy_ignore_timing: got seen=%b busy=%0d want 1 27", seen, nb); else n_pass++;
    // start raised in the done cycle must be ignored
    start = 1'b1; op = 2'd1; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    e = exp_q.pop_front();
    n_checks++; if ({hi, lo} !== e) $display("FAIL restart_result: got %h want %h", {hi, lo}, e); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL start_on_done: got busy=%b want 0", busy); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL stay_idle: got busy=%b done=%b want 0 0", busy, done); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arith();
    test_mt_div0();
    test_random();
    test_abort_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
Name: muldiv_hilo

Overview:
Iterative multi-cycle multiply/divide unit with the architectural HI/LO registers for the MIPS core. It replaces the single-cycle combinational MULT/DIV path in the ALU: the ALU keeps single-cycle ops, and this block takes the same register operands. It produces HI/LO for MFHI/MFLO and drives a busy signal that the control unit uses to stall.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  launch an operation; sampled only when busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  input  DATA_WIDTH  rs operand; multiplicand or dividend
b  input  DATA_WIDTH  rt operand; multiplier or divisor
mthi  input  1  write wdata to HI; ignored while busy
mtlo  input  1  write wdata to LO; ignored while busy
wdata  input  DATA_WIDTH  MTHI/MTLO data
busy  output  1  operation in flight; the core stalls MFHI/MFLO/MULT/DIV on it
done  output  1  one-cycle pulse when HI/LO are written by an operation
hi  output  DATA_WIDTH  HI register (registered, no bypass)
lo  output  DATA_WIDTH  LO register (registered, no bypass)

Behaviour:
- Reset (async, reset_n=0): state IDLE; hi=0, lo=0, busy=0, done=0; counter and working registers cleared. Reset mid-operation aborts it. HI/LO become 0 and no done pulse is issued.
- FSM states: IDLE, RUN, FINISH.
- IDLE + start=1 at edge E0:
  - Latch op and operand magnitudes (absolute value for MULT/DIV, raw for MULTU/DIVU).
  - Latch result sign flags; count=0; go to RUN.
  - busy=1 from the cycle after E0.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per edge, count 0..31. At the edge where count==31, go to FINISH.
- FINISH, next edge (E33):
  - Write hi/lo, pulse done=1 for exactly one cycle, busy=0, go to IDLE.
  - Total: busy high for 33 cycles, results visible the cycle after E33.
- Multiply: 64-bit product, hi=product[63:32], lo=product[31:0]. Signed result is negated when sign(a)^sign(b).
- Divide: lo=quotient, hi=remainder.
  - Signed: quotient negated if sign(a)^sign(b); remainder takes the sign of the dividend (truncating division).
  - Overflow case -2^31 / -1: lo=0x80000000, hi=0x00000000.
- Divide by zero (b==0, either signedness): full 33-cycle timing, done pulses, hi/lo left unchanged.
- start while busy: ignored, no queuing.
- mthi/mtlo while busy: ignored.
- In IDLE: mthi writes hi and mtlo writes lo at the edge. Both may be asserted in the same cycle and both are written.
- start together with mthi/mtlo in IDLE: start wins and the MT writes are dropped.
- start in the same cycle as done (FINISH→IDLE edge): ignored, because busy=1 in that cycle. The caller retries the next cycle.
- a/b/op need only be valid in the start cycle; later changes have no effect.

Decomposition:
- Shared package muldiv_pkg:
  - muldiv_op_t enum (MULT, MULTU, DIV, DIVU, values as above).
  - muldiv_state_t enum (IDLE, RUN, FINISH).
  - ITER_COUNT constant.
- Natural sub-module: muldiv_core, the unsigned 32-iteration shift-add / restoring-divide engine with a 64-bit accumulator.
- muldiv_hilo wraps muldiv_core and owns sign handling, the FSM, HI/LO and the MT writes.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> after 33 busy cycles done=1; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=7 -> lo=14, hi=2; then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi wdata=0x1234 and mtlo wdata=0x5678 in IDLE, then DIVU by b=0 -> done after 33 cycles; hi=0x1234, lo=0x5678 unchanged.
- Start MULT 7*9 and assert reset_n=0 at busy cycle 10 -> hi=lo=0, busy=0, no done. A new start after release gives lo=63. A second start and mthi issued while busy are both ignored.
